// File: rtl/ifetch_multi.sv
// Multi-beat instruction fetch from a byte-wide memory, with an external
// ICache hit bypass and a single-cycle cache fill strobe on miss completion.
module ifetch_multi #(
  parameter int ADDR_WIDTH = 8,
  parameter int M_WIDTH    = 8,
  parameter int INST_BYTES = 2,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic [ADDR_WIDTH-1:0]         pc,
  input  logic [M_WIDTH-1:0]            data_in,
  input  logic                          mem_ready,
  input  logic                          cache_hit,
  input  logic [INST_BYTES*M_WIDTH-1:0] cache_inst,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic                          mem_req,
  output logic [INST_BYTES*M_WIDTH-1:0] inst_out,
  output logic                          cache_we,
  output logic                          ready
);

  localparam int IW   = INST_BYTES * M_WIDTH;
  localparam int IDXW = $clog2(INST_BYTES) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(INST_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} state_t;

  state_t              r_state, w_state;
  logic [IDXW-1:0]     r_idx, w_idx;
  logic                r_fill, w_fill;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic                r_mem_req, w_mem_req;
  logic [IW-1:0]       r_inst, w_inst;
  logic                r_cache_we, w_cache_we;
  logic                r_ready, w_ready;

  logic [IDXW-1:0]     w_lane;
  logic [IW-1:0]       w_mask;

  // Byte lane written by the current beat; the mask selects that lane only.
  assign w_lane = (BIG_ENDIAN != 0) ? (LAST_IDX - r_idx) : r_idx;

  for (genvar g = 0; g < INST_BYTES; g++) begin : g_lane
    assign w_mask[g*M_WIDTH +: M_WIDTH] = {M_WIDTH{w_lane == IDXW'(g)}};
  end

  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_fill     = r_fill;
    w_addr     = r_addr;
    w_mem_req  = r_mem_req;
    w_inst     = r_inst;
    w_cache_we = r_cache_we;
    w_ready    = r_ready;

    if (!en || flush) begin
      w_state    = IDLE;
      w_ready    = 1'b0;
      w_mem_req  = 1'b0;
      w_cache_we = 1'b0;
      w_idx      = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cache_hit) begin
            w_inst  = cache_inst;
            w_fill  = 1'b0;
            w_state = DONE;
          end else begin
            w_addr    = pc;
            w_mem_req = 1'b1;
            w_idx     = '0;
            w_fill    = 1'b1;
            w_state   = WAIT;
          end
        end
        ISSUE: begin
          w_addr    = pc + ADDR_WIDTH'(r_idx);
          w_mem_req = 1'b1;
          w_state   = WAIT;
        end
        WAIT: begin
          if (mem_ready && r_mem_req) begin
            w_mem_req = 1'b0;
            w_inst    = (r_inst & ~w_mask) | ({INST_BYTES{data_in}} & w_mask);
            if (r_idx == LAST_IDX) begin
              w_state = DONE;
            end else begin
              w_idx   = r_idx + 1'b1;
              w_state = ISSUE;
            end
          end
        end
        DONE: begin
          w_ready    = 1'b1;
          w_cache_we = r_fill;
          w_state    = HOLD;
        end
        HOLD: begin
          w_cache_we = 1'b0;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_fill     <= 1'b0;
      r_addr     <= '0;
      r_mem_req  <= 1'b0;
      r_inst     <= '0;
      r_cache_we <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_fill     <= w_fill;
      r_addr     <= w_addr;
      r_mem_req  <= w_mem_req;
      r_inst     <= w_inst;
      r_cache_we <= w_cache_we;
      r_ready    <= w_ready;
    end
  end

  assign addr     = r_addr;
  assign mem_req  = r_mem_req;
  assign inst_out = r_inst;
  assign cache_we = r_cache_we;
  assign ready    = r_ready;

endmodule

// File: tb/tb_ifetch_multi.sv
// Scoreboard bench for ifetch_multi: a 2-byte big-endian instance with a
// delay-programmable memory responder, plus a 3-byte little-endian instance.
module tb_ifetch_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, flush, mem_ready, cache_hit;
  logic [7:0]  pc, data_in, addr;
  logic [15:0] cache_inst, inst_out;
  logic        mem_req, cache_we, ready;

  logic        en_b, mem_ready_b;
  logic        flush_b = 1'b0;
  logic        cache_hit_b = 1'b0;
  logic [23:0] cache_inst_b = 24'h0;
  logic [7:0]  pc_b, data_in_b, addr_b;
  logic [23:0] inst_out_b;
  logic        mem_req_b, cache_we_b, ready_b;

  logic [7:0]  mem [256];
  logic [7:0]  exp_addr [$];
  logic [15:0] exp_inst [$];
  logic        exp_we   [$];

  int n_pass = 0;
  int n_total = 0;
  int we_pulses = 0;
  int resp_delay = 0;
  bit spurious = 1'b0;

  ifetch_multi #(.ADDR_WIDTH(8), .M_WIDTH(8), .INST_BYTES(2), .BIG_ENDIAN(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .pc(pc), .data_in(data_in),
    .mem_ready(mem_ready), .cache_hit(cache_hit), .cache_inst(cache_inst),
    .addr(addr), .mem_req(mem_req), .inst_out(inst_out), .cache_we(cache_we), .ready(ready)
  );

  ifetch_multi #(.ADDR_WIDTH(8), .M_WIDTH(8), .INST_BYTES(3), .BIG_ENDIAN(0)) u_dut_le (
    .clk(clk), .rst(rst), .en(en_b), .flush(flush_b), .pc(pc_b), .data_in(data_in_b),
    .mem_ready(mem_ready_b), .cache_hit(cache_hit_b), .cache_inst(cache_inst_b),
    .addr(addr_b), .mem_req(mem_req_b), .inst_out(inst_out_b), .cache_we(cache_we_b), .ready(ready_b)
  );

  // Memory responder for u_dut: answers resp_delay cycles after mem_req rises.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (cnt >= resp_delay) begin
          mem_ready = 1'b1;
          data_in = mem[addr];
        end else begin
          mem_ready = 1'b0;
          data_in = 8'h00;
          cnt++;
        end
      end else begin
        cnt = 0;
        mem_ready = spurious;
        data_in = spurious ? 8'hEE : 8'h00;
      end
    end
  end

  // Scoreboard monitor: each new beat and each completed fetch pops an expectation.
  initial begin
    logic prev_req, prev_rdy, ew;
    logic [7:0] ea;
    logic [15:0] ei;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cache_we === 1'b1) we_pulses++;
      if (mem_req === 1'b1 && !prev_req) begin
        n_total++;
        if (exp_addr.size() == 0) $display("FAIL unexpected_mem_req: addr=%h, no beat expected", addr);
        else begin
          ea = exp_addr.pop_front();
          if (addr !== ea) $display("FAIL beat_addr: got %h want %h", addr, ea);
          else n_pass++;
        end
      end
      if (ready === 1'b1 && !prev_rdy) begin
        n_total++;
        if (exp_inst.size() == 0) $display("FAIL unexpected_ready: inst_out=%h", inst_out);
        else begin
          ei = exp_inst.pop_front();
          if (inst_out !== ei) $display("FAIL inst_out: got %h want %h", inst_out, ei);
          else n_pass++;
        end
        n_total++;
        if (exp_we.size() == 0) $display("FAIL unexpected_fill: cache_we=%b", cache_we);
        else begin
          ew = exp_we.pop_front();
          if (cache_we !== ew) $display("FAIL cache_we_at_ready: got %b want %b", cache_we, ew);
          else n_pass++;
        end
      end
      prev_req = (mem_req === 1'b1);
      prev_rdy = (ready === 1'b1);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", addr); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if (inst_out !== 16'h0) $display("FAIL rst_inst: got %h want 0000", inst_out); else n_pass++;
    n_total++; if (cache_we !== 1'b0) $display("FAIL rst_cache_we: got %b want 0", cache_we); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else n_pass++;
    n_total++; if (inst_out_b !== 24'h0) $display("FAIL rst_inst_b: got %h want 000000", inst_out_b); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_miss_be();
    logic [4:0] pat;
    int lat, we0, bad;
    mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD;
    @(negedge clk);
    we0 = we_pulses;
    exp_addr.push_back(8'h10); exp_addr.push_back(8'h11);
    exp_inst.push_back(16'hABCD); exp_we.push_back(1'b1);
    pc = 8'h10; en = 1'b1;
    pat = '0; lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      pat = {mem_req, pat[4:1]};
      if (ready === 1'b1 && lat == 0) lat = k;
    end
    n_total++; if (pat !== 5'b00101) $display("FAIL miss_req_pattern: got %b want 00101", pat); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL miss_latency: got %0d want 5", lat); else n_pass++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || inst_out !== 16'hABCD || cache_we !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL miss_hold: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (we_pulses - we0 !== 1) $display("FAIL miss_we_pulses: got %0d want 1", we_pulses - we0); else n_pass++;
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ready !== 1'b0) $display("FAIL en_drop_ready: got %b want 0", ready); else n_pass++;
    n_total++; if (inst_out !== 16'hABCD) $display("FAIL en_drop_inst_kept: got %h want abcd", inst_out); else n_pass++;
    n_total++; if (exp_addr.size() + exp_inst.size() != 0) $display("FAIL miss_scoreboard_left: got %0d want 0", exp_addr.size() + exp_inst.size()); else n_pass++;
  endtask

  task automatic test_hit();
    int lat, we0, reqs;
    @(negedge clk);
    we0 = we_pulses;
    exp_inst.push_back(16'h1234); exp_we.push_back(1'b0);
    cache_hit = 1'b1; cache_inst = 16'h1234; pc = 8'h40; en = 1'b1;
    lat = 0; reqs = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b0) reqs++;
      if (ready === 1'b1 && lat == 0) lat = k;
    end
    n_total++; if (reqs !== 0) $display("FAIL hit_mem_req: got %0d cycles want 0", reqs); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL hit_latency: got %0d want 2", lat); else n_pass++;
    n_total++; if (inst_out !== 16'h1234) $display("FAIL hit_inst: got %h want 1234", inst_out); else n_pass++;
    n_total++; if (we_pulses - we0 !== 0) $display("FAIL hit_we_pulses: got %0d want 0", we_pulses - we0); else n_pass++;
    @(negedge clk); en = 1'b0; cache_hit = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_delayed();
    logic [10:0] pat;
    int lat, we0, bad;
    mem[8'h30] = 8'h5A;
    mem[8'h31] = 8'hC3;
    resp_delay = 3; spurious = 1'b1;
    @(negedge clk);
    we0 = we_pulses;
    exp_addr.push_back(8'h30); exp_addr.push_back(8'h31);
    exp_inst.push_back(16'h5AC3); exp_we.push_back(1'b1);
    pc = 8'h30; en = 1'b1;
    pat = '0; lat = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      pat = {mem_req, pat[10:1]};
      if (ready === 1'b1 && lat == 0) lat = k;
    end
    n_total++; if (pat !== 11'h1EF) $display("FAIL delay_req_pattern: got %b want 00111101111", pat); else n_pass++;
    n_total++; if (lat !== 11) $display("FAIL delay_latency: got %0d want 11", lat); else n_pass++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || inst_out !== 16'h5AC3) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL spurious_ready_hold: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (we_pulses - we0 !== 1) $display("FAIL delay_we_pulses: got %0d want 1", we_pulses - we0); else n_pass++;
    @(negedge clk); en = 1'b0; spurious = 1'b0; resp_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat, we0;
    bit found;
    mem[8'h50] = 8'h77;
    mem[8'h51] = 8'h88;
    resp_delay = 3;
    @(negedge clk);
    we0 = we_pulses;
    exp_addr.push_back(8'h50); exp_addr.push_back(8'h51);
    pc = 8'h50; en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1 && addr === 8'h51) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL flush_reach_wait2: got %b want 1", found); else n_pass++;
    flush = 1'b1; resp_delay = 0;
    exp_addr.push_back(8'h50); exp_addr.push_back(8'h51);
    exp_inst.push_back(16'h7788); exp_we.push_back(1'b1);
    @(posedge clk); #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL flush_mem_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", ready); else n_pass++;
    flush = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) lat = k;
    end
    n_total++; if (lat !== 5) $display("FAIL refetch_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (inst_out !== 16'h7788) $display("FAIL refetch_inst: got %h want 7788", inst_out); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (we_pulses - we0 !== 1) $display("FAIL flush_we_pulses: got %0d want 1", we_pulses - we0); else n_pass++;
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort_both();
    int reqs;
    mem[8'h70] = 8'hF0;
    resp_delay = 0;
    @(negedge clk);
    exp_addr.push_back(8'h70);
    pc = 8'h70; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL abort_mem_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", ready); else n_pass++;
    n_total++; if (inst_out !== 16'h7788) $display("FAIL abort_inst_kept: got %h want 7788", inst_out); else n_pass++;
    flush = 1'b0;
    reqs = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (mem_req !== 1'b0) reqs++;
    end
    n_total++; if (reqs !== 0) $display("FAIL abort_idle_req: got %0d cycles want 0", reqs); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, we0;
    bit found;
    mem[8'h60] = 8'h9A;
    mem[8'h61] = 8'hBC;
    resp_delay = 3;
    @(negedge clk);
    exp_addr.push_back(8'h60); exp_addr.push_back(8'h61);
    pc = 8'h60; en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1 && addr === 8'h61) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL rstmid_reach_wait2: got %b want 1", found); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rstmid_mem_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready); else n_pass++;
    n_total++; if (addr !== 8'h00) $display("FAIL rstmid_addr: got %h want 00", addr); else n_pass++;
    n_total++; if (inst_out !== 16'h0) $display("FAIL rstmid_inst: got %h want 0000", inst_out); else n_pass++;
    resp_delay = 0;
    exp_addr.push_back(8'h60); exp_addr.push_back(8'h61);
    exp_inst.push_back(16'h9ABC); exp_we.push_back(1'b1);
    we0 = we_pulses;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) lat = k;
    end
    n_total++; if (lat !== 5) $display("FAIL rstmid_refetch_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (inst_out !== 16'h9ABC) $display("FAIL rstmid_refetch_inst: got %h want 9abc", inst_out); else n_pass++;
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    n_total++; if (we_pulses - we0 !== 1) $display("FAIL rstmid_we_pulses: got %0d want 1", we_pulses - we0); else n_pass++;
    n_total++; if (exp_addr.size() + exp_inst.size() + exp_we.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", exp_addr.size() + exp_inst.size() + exp_we.size()); else n_pass++;
  endtask

  task automatic test_wrap_le();
    logic [7:0] q [$];
    logic [7:0] ea;
    logic prev;
    int lat, wec;
    mem[8'hFF] = 8'h11;
    mem[8'h00] = 8'h22;
    mem[8'h01] = 8'h33;
    q.push_back(8'hFF); q.push_back(8'h00); q.push_back(8'h01);
    @(negedge clk);
    pc_b = 8'hFF; en_b = 1'b1; mem_ready_b = 1'b0;
    prev = 1'b0; lat = 0; wec = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (mem_req_b === 1'b1 && !prev) begin
        n_total++;
        if (q.size() == 0) $display("FAIL le_unexpected_req: addr=%h, no beat expected", addr_b);
        else begin
          ea = q.pop_front();
          if (addr_b !== ea) $display("FAIL le_beat_addr: got %h want %h", addr_b, ea);
          else n_pass++;
        end
      end
      prev = (mem_req_b === 1'b1);
      if (cache_we_b === 1'b1) wec++;
      if (ready_b === 1'b1 && lat == 0) lat = k;
      @(negedge clk);
      mem_ready_b = mem_req_b;
      data_in_b = mem[addr_b];
    end
    n_total++; if (lat !== 7) $display("FAIL le_latency: got %0d want 7", lat); else n_pass++;
    n_total++; if (inst_out_b !== 24'h332211) $display("FAIL le_inst: got %h want 332211", inst_out_b); else n_pass++;
    n_total++; if (wec !== 1) $display("FAIL le_we_pulses: got %0d want 1", wec); else n_pass++;
    n_total++; if (q.size() != 0) $display("FAIL le_beats_left: got %0d want 0", q.size()); else n_pass++;
    en_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; pc = 8'h00;
    cache_hit = 1'b0; cache_inst = 16'h0;
    en_b = 1'b0; pc_b = 8'h00; mem_ready_b = 1'b0; data_in_b = 8'h00;
    for (int i = 0; i < 256; i++) mem[8'(i)] = 8'(i) ^ 8'h5A;
    test_reset();
    test_miss_be();
    test_hit();
    test_delayed();
    test_flush();
    test_abort_both();
    test_reset_mid();
    test_wrap_le();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_multi.md
IFETCH_MULTI -- requirements
Module: ifetch_multi

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the memory address and pc width.
REQ-002 SHALL have parameter M_WIDTH, default 8, meaning the memory data (byte) width.
REQ-003 SHALL have parameter INST_BYTES, default 2, range 1..8, meaning bytes per instruction; IW = INST_BYTES*M_WIDTH.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1: 1 means the byte at pc is most significant, 0 means it is least significant.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port en  in  1  fetch enable; held high for the whole fetch.
REQ-008 SHALL have port flush  in  1  abort the current fetch.
REQ-009 SHALL have port pc  in  ADDR_WIDTH  instruction address; must be stable while en=1.
REQ-010 SHALL have port data_in  in  M_WIDTH  memory read data, valid when mem_ready=1.
REQ-011 SHALL have port mem_ready  in  1  memory beat complete.
REQ-012 SHALL have port cache_hit  in  1  external ICache hit for pc.
REQ-013 SHALL have port cache_inst  in  IW  external ICache data for pc.
REQ-014 SHALL have port addr  out  ADDR_WIDTH  memory byte address.
REQ-015 SHALL have port mem_req  out  1  memory read request.
REQ-016 SHALL have port inst_out  out  IW  assembled instruction; also the cache write data.
REQ-017 SHALL have port cache_we  out  1  single-cycle ICache fill strobe.
REQ-018 SHALL have port ready  out  1  inst_out valid.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE, HOLD, plus a byte index idx of width clog2(INST_BYTES)+1.
REQ-020 In IDLE with en=1, flush=0 and cache_hit=1, the block SHALL load inst_out<=cache_inst and go to DONE with no memory access; the DONE entry SHALL record fill=0.
REQ-021 In IDLE with en=1, flush=0 and cache_hit=0, the block SHALL set addr<=pc, mem_req<=1 and idx<=0, and go to WAIT; it SHALL record fill=1.
REQ-022 In WAIT, mem_ready=0 SHALL hold all state; mem_req SHALL stay asserted until mem_ready.
REQ-023 In WAIT with mem_ready=1, the block SHALL set mem_req<=0 and write data_in to lane (INST_BYTES-1-idx) when BIG_ENDIAN=1, or to lane idx when BIG_ENDIAN=0; lane k = bits [k*M_WIDTH +: M_WIDTH].
REQ-024 After that WAIT write, the block SHALL go to DONE if idx=INST_BYTES-1, else set idx<=idx+1 and go to ISSUE.
REQ-025 In ISSUE, the block SHALL set addr<=pc+idx (modulo 2^ADDR_WIDTH) and mem_req<=1, and go to WAIT; mem_req therefore drops for exactly one cycle between beats.
REQ-026 Address arithmetic SHALL wrap: pc=2^ADDR_WIDTH-1 fetches its next byte from address 0.
REQ-027 DONE SHALL set ready<=1, set cache_we<=fill, and go to HOLD.
REQ-028 HOLD SHALL set cache_we<=0 and keep ready=1 and inst_out stable until en=0 or flush=1.
REQ-029 en=0 or flush=1, sampled in any state, SHALL on that edge force IDLE, ready<=0, mem_req<=0, cache_we<=0 and idx<=0; inst_out SHALL keep its last value.
REQ-030 Any mem_ready accepted while mem_req=0 SHALL be ignored.
REQ-031 When en=0 and flush=1 occur together, the block SHALL apply REQ-029 once, with no other effect.
REQ-032 If fetch start is the first edge with en=1 in IDLE, latency SHALL be: on a hit, ready=1 after edge 2; on a miss with mem_ready high in every WAIT cycle, ready=1 after edge 2*INST_BYTES+1.
REQ-033 cache_we SHALL be high for exactly one cycle per miss fetch, coincident with the first ready=1 cycle, and never on a hit.

Reset
REQ-034 rst=1 SHALL asynchronously force state=IDLE, idx=0, fill=0, addr=0, mem_req=0, inst_out=0, cache_we=0 and ready=0.
REQ-035 Reset asserted mid-fetch SHALL abandon the fetch; after rst falls with en=1, a fresh fetch SHALL start at byte 0.

Verification
REQ-036 Bench: INST_BYTES=2, BIG_ENDIAN=1, pc=0x10, miss, mem[0x10]=0xAB, mem[0x11]=0xCD -> addr 0x10 then 0x11, inst_out=0xABCD, ready after edge 5, one cache_we pulse.
REQ-037 Bench: INST_BYTES=3, BIG_ENDIAN=0, pc=0xFF, bytes 0x11/0x22/0x33 -> addr 0xFF, 0x00, 0x01; inst_out=0x332211.
REQ-038 Bench: hit with cache_inst=0x1234 -> mem_req never asserts, inst_out=0x1234, ready after edge 2, cache_we stays 0.
REQ-039 Bench: miss with mem_ready delayed 3 cycles per beat -> mem_req held through the wait, 1-cycle gap between beats, correct inst_out.
REQ-040 Bench: flush (or rst) during the second WAIT -> next edge (or immediately for rst) mem_req=0, ready=0; a refetch from pc completes correctly.
